// File: rtl/sd_adc_conv_ctrl.sv
// Conversion sequencer for the sigma-delta ADC core: clear, settle, average, handshake.
// Optional build macro SD_ADC_CTRL_ROUND_EN selects round-half-up averaging instead of truncation.
//
// state  | meaning
// IDLE   | modulator off, waiting for start
// CLEAR  | one-cycle accumulator clear pulse, modulator enabled
// SETTLE | discarding the first SETTLE_WIN window results
// ACQ    | summing 2^AVG_LOG2 window results per output sample
module sd_adc_conv_ctrl #(
    parameter int ACC_W      = 8,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_WIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_cont,
    output logic             adc_en,
    output logic             adc_clr,
    input  logic [ACC_W-1:0] accum,
    input  logic             accum_rdy,
    output logic [ACC_W-1:0] digital_out,
    output logic             sample_rdy,
    input  logic             sample_ack,
    output logic             busy,
    output logic             overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_ACQ    = 2'd3;

    localparam int SUM_W = ACC_W + AVG_LOG2;
    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int MAX_N = (SETTLE_WIN > AVG_N) ? SETTLE_WIN : AVG_N;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] AVG_CNT = CNT_W'(AVG_N);
    localparam logic [CNT_W-1:0] SET_CNT = CNT_W'(SETTLE_WIN);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             mode_q, mode_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             rdy_q, rdy_d;
    logic             ovr_q, ovr_d;
    logic [SUM_W-1:0] sum_tot, sum_res;
    logic [ACC_W-1:0] avg_res;

    assign sum_tot = sum_q + SUM_W'(accum);
`ifdef SD_ADC_CTRL_ROUND_EN
    // Half an LSB of the output; collapses to zero when no averaging is done.
    localparam logic [SUM_W-1:0] RND = SUM_W'((1 << AVG_LOG2) >> 1);
    assign sum_res = sum_tot + RND;
`else
    assign sum_res = sum_tot;
`endif
    assign avg_res = ACC_W'(sum_res >> AVG_LOG2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        rdy_d   = sample_ack ? 1'b0 : rdy_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_IDLE: begin
                sum_d = '0;
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_CLEAR;
                    mode_d  = mode_cont;
                    ovr_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                if (SETTLE_WIN == 0) begin
                    state_d = S_ACQ;
                    cnt_d   = AVG_CNT;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = SET_CNT;
                end
            end
            S_SETTLE: begin
                if (accum_rdy) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_ACQ;
                        cnt_d   = AVG_CNT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                if (accum_rdy) begin
                    if (cnt_q == CNT_W'(1)) begin
                        dout_d = avg_res;
                        rdy_d  = 1'b1;
                        if (rdy_q && !sample_ack) ovr_d = 1'b1;
                        sum_d  = '0;
                        cnt_d  = AVG_CNT;
                        if (!mode_q) state_d = S_IDLE;
                    end else begin
                        sum_d = sum_tot;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
        endcase
        // Abort keeps the last presented sample and its handshake intact.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            dout_d  = dout_q;
            rdy_d   = sample_ack ? 1'b0 : rdy_q;
            ovr_d   = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            mode_q  <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_en      = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign adc_clr     = (state_q == S_CLEAR);
    assign digital_out = dout_q;
    assign sample_rdy  = rdy_q;
    assign overrun     = ovr_q;

endmodule
